bit_serializer: RTL
===================

BIT_SERIALIZER -- requirements
Module: bit_serializer

Interface
REQ-001 The module SHALL have parameter WIDTH, default 8, giving the parallel word width (4..16).
REQ-002 The module SHALL have parameter IDLE_BIT, default 1'b0, giving the value driven on w while w_valid=0.
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The module SHALL have port Reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The module SHALL have port din, input, WIDTH bits: the parallel word to serialize.
REQ-006 The module SHALL have port len, input, clog2(WIDTH) bits: the word length minus one, so the word has len+1 bits.
REQ-007 The module SHALL have port din_valid, input, 1 bit: a word is offered on din/len.
REQ-008 The module SHALL have port din_ready, output, 1 bit: the block can accept a word this cycle.
REQ-009 The module SHALL have port w_en, input, 1 bit: downstream advance enable; 0 stalls the shifter.
REQ-010 The module SHALL have port w, output, 1 bit: the serial bit stream feeding the sequence-detector w input.
REQ-011 The module SHALL have port w_valid, output, 1 bit: w carries a data bit this cycle.
REQ-012 The module SHALL have port busy, output, 1 bit: the module is in SHIFT or the hold register is full.

Function
REQ-013 A word SHALL be accepted on a rising edge where din_valid=1 and din_ready=1; din and len are captured together.
REQ-014 din_ready SHALL equal NOT hold_full, where hold_full marks a one-entry holding register; it is a pure decode of registered state.
REQ-015 The FSM SHALL have exactly two states: IDLE (w_valid=0, w=IDLE_BIT) and SHIFT (w_valid=1).
REQ-016 In IDLE, an accepted word SHALL load directly into the shift register and go to SHIFT, so the first bit appears on w one cycle after acceptance.
REQ-017 Bit order SHALL be MSB-first from bit len: din[len], din[len-1], ..., din[0]; din bits above len are ignored.
REQ-018 In SHIFT with w_en=1, each edge SHALL advance one bit and decrement the bit counter.
REQ-019 In SHIFT with w_en=0, w, w_valid and the bit counter SHALL hold.
REQ-020 A word accepted in SHIFT SHALL go to the hold register, unless that same edge advances the last bit, in which case it loads directly into the shift register.
REQ-021 On a last-bit advance, the next word SHALL load with priority hold register > simultaneously accepted word; with no word pending, the FSM goes to IDLE.
REQ-022 Consecutive words SHALL produce no bubble: w_valid stays 1 across the word boundary.
REQ-023 w_en SHALL have no effect in IDLE.
REQ-024 len=0 SHALL yield a single-bit word lasting one advancing cycle.

Reset
REQ-025 While Reset=1, the module SHALL drive state=IDLE, w_valid=0, w=IDLE_BIT, busy=0, hold_full=0 (so din_ready=1), and clear the counter and shift register.
REQ-026 Reset asserted mid-word SHALL discard the shift and hold contents immediately; no remaining bits appear after release.

Structure
REQ-027 The state encoding and the IDLE_BIT default SHALL live in the shared package bit_serializer_pkg.
REQ-028 The shift register, counter and hold register SHALL be inline; no sub-module is required.

Verification
REQ-029 The bench SHALL check: WIDTH=8, din=8'hB2, len=7, one-cycle valid -> w_valid=1 for the next 8 cycles with w = 1,0,1,1,0,0,1,0, then w_valid=0 and w=IDLE_BIT.
REQ-030 The bench SHALL check: din=8'hFF then 8'h00, din_valid held, len=7 -> 16 contiguous w_valid cycles (8 ones then 8 zeros); din_ready=0 from the second accept until the first word's last bit.
REQ-031 The bench SHALL check: 8'hB2 with w_en=0 for 3 cycles after the 3rd bit -> w holds 1 during the stall; the word spans 11 cycles with the bit sequence unchanged.
REQ-032 The bench SHALL check: din=8'h05, len=2 -> w = 1,0,1 over 3 cycles; len=0, din=8'h01 -> a single 1 for one cycle.
REQ-033 The bench SHALL check: Reset pulse after 3 bits with the hold register full -> w_valid=0 and din_ready=1 asynchronously; no bits emitted after release until a new accept.
REQ-034 The bench SHALL check: a word accepted on the same edge as the last-bit advance with hold empty -> its first bit appears on the next cycle with no gap.

Source files
------------

// File: rtl/bit_serializer_pkg.sv
// Shared definitions for the parallel-to-serial front end of the sequence detector.
package bit_serializer_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_e;

    localparam logic IDLE_BIT_DEFAULT = 1'b0;

endpackage

// File: rtl/bit_serializer.sv
// Serializes variable-length parallel words MSB-first onto w, with a one-entry
// holding register so back-to-back words stream without a bubble.
module bit_serializer
    import bit_serializer_pkg::*;
#(
    parameter int unsigned WIDTH    = 8,
    parameter logic        IDLE_BIT = IDLE_BIT_DEFAULT
) (
    input  logic                       clk,
    input  logic                       Reset,
    input  logic [WIDTH-1:0]           din,
    input  logic [$clog2(WIDTH)-1:0]   len,
    input  logic                       din_valid,
    output logic                       din_ready,
    input  logic                       w_en,
    output logic                       w,
    output logic                       w_valid,
    output logic                       busy
);

    localparam int unsigned LW = $clog2(WIDTH);

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  shift_q, shift_d;
    logic [LW-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]  hold_data_q, hold_data_d;
    logic [LW-1:0]     hold_len_q, hold_len_d;
    logic              hold_full_q, hold_full_d;
    logic              w_q, w_d;
    logic              w_valid_q, w_valid_d;
    logic              busy_q, busy_d;
    logic              accept_c;
    logic              last_adv_c;

    // Left-justify so bit 'len' lands in the MSB; bits above len fall off the top.
    function automatic logic [WIDTH-1:0] align_msb(input logic [WIDTH-1:0] d,
                                                   input logic [LW-1:0]    l);
        logic [LW-1:0] l_eff;
        l_eff = (32'(l) > WIDTH - 1) ? LW'(WIDTH - 1) : l;
        return d << (LW'(WIDTH - 1) - l_eff);
    endfunction

    assign accept_c   = din_valid & ~hold_full_q;
    assign last_adv_c = (state_q == ST_SHIFT) & w_en & (cnt_q == '0);

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            state_q     <= ST_IDLE;
            shift_q     <= '0;
            cnt_q       <= '0;
            hold_data_q <= '0;
            hold_len_q  <= '0;
            hold_full_q <= 1'b0;
            w_q         <= IDLE_BIT;
            w_valid_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            cnt_q       <= cnt_d;
            hold_data_q <= hold_data_d;
            hold_len_q  <= hold_len_d;
            hold_full_q <= hold_full_d;
            w_q         <= w_d;
            w_valid_q   <= w_valid_d;
            busy_q      <= busy_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        cnt_d       = cnt_q;
        hold_data_d = hold_data_q;
        hold_len_d  = hold_len_q;
        hold_full_d = hold_full_q;

        unique case (state_q)
            ST_IDLE: begin
                if (accept_c) begin
                    shift_d = align_msb(din, len);
                    cnt_d   = len;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (last_adv_c) begin
                    // Held word has priority; an accept cannot coincide with a full hold.
                    if (hold_full_q) begin
                        shift_d     = align_msb(hold_data_q, hold_len_q);
                        cnt_d       = hold_len_q;
                        hold_full_d = 1'b0;
                    end else if (accept_c) begin
                        shift_d = align_msb(din, len);
                        cnt_d   = len;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    if (w_en) begin
                        shift_d = shift_q << 1;
                        cnt_d   = cnt_q - LW'(1);
                    end
                    if (accept_c) begin
                        hold_data_d = din;
                        hold_len_d  = len;
                        hold_full_d = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        w_valid_d = (state_d == ST_SHIFT);
        w_d       = w_valid_d ? shift_d[WIDTH-1] : IDLE_BIT;
        busy_d    = w_valid_d | hold_full_d;
    end

    assign din_ready = ~hold_full_q;
    assign w         = w_q;
    assign w_valid   = w_valid_q;
    assign busy      = busy_q;

endmodule
